// File: rtl/i2s_sample_rx.sv
// I2S slave receiver: oversamples bclk/lrck/sdata in the clk domain and emits
// sign-extended stereo sample pairs with a one-cycle valid strobe.
module i2s_sample_rx #(
  parameter int unsigned DATA_BITS = 24,
  parameter int unsigned W         = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         bclk,
  input  logic         lrck,
  input  logic         sdata,
  output logic [W-1:0] sample_l,
  output logic [W-1:0] sample_r,
  output logic         valid,
  output logic         frame_err
);

  localparam int unsigned CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CntLast = CW'(DATA_BITS);

  typedef enum logic [1:0] {StIdle, StDelay, StShift, StWait} state_e;

  state_e               state_q, state_d;
  logic [2:0]           bclk_sync_q, bclk_sync_d;  // [0],[1] synchroniser, [2] edge history
  logic [1:0]           lrck_sync_q, lrck_sync_d;
  logic [1:0]           sdata_sync_q, sdata_sync_d;
  logic                 lrck_prev_q, lrck_prev_d;
  logic                 chan_q, chan_d;
  logic                 left_ok_q, left_ok_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [W-1:0]         hold_l_q, hold_l_d;
  logic [W-1:0]         hold_r_q, hold_r_d;
  logic                 load_q, load_d;
  logic [W-1:0]         sample_l_q, sample_l_d;
  logic [W-1:0]         sample_r_q, sample_r_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic                 bclk_rise, lrck_s, sdata_s, lrck_chg;
  logic [DATA_BITS-1:0] shift_in;
  logic [CW-1:0]        cnt_inc;

  function automatic logic [W-1:0] sext(input logic [DATA_BITS-1:0] word);
    return W'($signed(word));
  endfunction

  always_comb begin
    bclk_sync_d  = {bclk_sync_q[1:0], bclk};
    lrck_sync_d  = {lrck_sync_q[0], lrck};
    sdata_sync_d = {sdata_sync_q[0], sdata};

    bclk_rise = bclk_sync_q[1] & ~bclk_sync_q[2];
    lrck_s    = lrck_sync_q[1];
    sdata_s   = sdata_sync_q[1];
    lrck_chg  = lrck_s ^ lrck_prev_q;
    shift_in  = {shift_q[DATA_BITS-2:0], sdata_s};
    cnt_inc   = cnt_q + CW'(1);

    state_d     = state_q;
    lrck_prev_d = lrck_prev_q;
    chan_d      = chan_q;
    left_ok_d   = left_ok_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    load_d      = 1'b0;
    sample_l_d  = sample_l_q;
    sample_r_d  = sample_r_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;

    if (load_q && en) begin
      sample_l_d = hold_l_q;
      sample_r_d = hold_r_q;
      valid_d    = 1'b1;
    end

    if (bclk_rise) begin
      lrck_prev_d = lrck_s;
    end

    if (!en) begin
      state_d   = StIdle;
      left_ok_d = 1'b0;
    end else if (bclk_rise) begin
      unique case (state_q)
        StIdle: begin
          if (lrck_chg && !lrck_s) begin
            chan_d    = 1'b0;
            left_ok_d = 1'b0;
            state_d   = StDelay;
          end
        end
        StDelay: begin
          if (lrck_chg) begin
            err_d     = 1'b1;
            left_ok_d = 1'b0;
            chan_d    = lrck_s;
          end else begin
            // This rise carries the MSB, so the count starts at one.
            shift_d = shift_in;
            cnt_d   = CW'(1);
            state_d = StShift;
          end
        end
        StShift: begin
          if (lrck_chg) begin
            err_d     = 1'b1;
            left_ok_d = 1'b0;
            chan_d    = lrck_s;
            state_d   = StDelay;
          end else begin
            shift_d = shift_in;
            cnt_d   = cnt_inc;
            if (cnt_inc == CntLast) begin
              state_d = StWait;
              if (!chan_q) begin
                hold_l_d  = sext(shift_in);
                left_ok_d = 1'b1;
              end else if (left_ok_q) begin
                hold_r_d = sext(shift_in);
                load_d   = 1'b1;
              end
            end
          end
        end
        StWait: begin
          if (lrck_chg) begin
            chan_d  = lrck_s;
            state_d = StDelay;
            if (!lrck_s) left_ok_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      bclk_sync_q  <= '0;
      lrck_sync_q  <= '0;
      sdata_sync_q <= '0;
      lrck_prev_q  <= 1'b0;
      chan_q       <= 1'b0;
      left_ok_q    <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      load_q       <= 1'b0;
      sample_l_q   <= '0;
      sample_r_q   <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bclk_sync_q  <= bclk_sync_d;
      lrck_sync_q  <= lrck_sync_d;
      sdata_sync_q <= sdata_sync_d;
      lrck_prev_q  <= lrck_prev_d;
      chan_q       <= chan_d;
      left_ok_q    <= left_ok_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      load_q       <= load_d;
      sample_l_q   <= sample_l_d;
      sample_r_q   <= sample_r_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign sample_l  = sample_l_q;
  assign sample_r  = sample_r_q;
  assign valid     = valid_q;
  assign frame_err = err_q;

endmodule
